// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port PicoComputer memory (IDLE -> ACC -> DONE).
// Build option ARB_FIXED_PRIO_EN: requester 0 always wins ties; otherwise ties are round-robin.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_out,
    output logic                  busy
);

    // Handshake: reqN/weN/addrN/wdataN are held stable until ackN; ackN pulses for
    // exactly one cycle (the DONE cycle) and the requester drops reqN after seeing it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   owner;
    logic   owner_next;

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority needs no history: requester 0 wins whenever it asks.
    always_comb begin
        state_next = state;
        owner_next = owner;
        case (state)
            IDLE: begin
                if (req0) begin
                    owner_next = 1'b0;
                    state_next = ACC;
                end else if (req1) begin
                    owner_next = 1'b1;
                    state_next = ACC;
                end
            end
            ACC:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
`else
    logic last_owner;

    // On a tie the grant goes to whoever was not served last.
    always_comb begin
        state_next = state;
        owner_next = owner;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    owner_next = ~last_owner;
                    state_next = ACC;
                end else if (req0) begin
                    owner_next = 1'b0;
                    state_next = ACC;
                end else if (req1) begin
                    owner_next = 1'b1;
                    state_next = ACC;
                end
            end
            ACC:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= 1'b1;
        end else if (state == ACC) begin
            last_owner <= owner;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            state <= state_next;
            owner <= owner_next;
        end
    end

    // Acks are set on the edge that ends ACC and cleared on the edge that ends DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            if (state == ACC) begin
                if (owner) begin
                    ack1 <= 1'b1;
                    if (!we1) begin
                        rdata1 <= mem_out;
                    end
                end else begin
                    ack0 <= 1'b1;
                    if (!we0) begin
                        rdata0 <= mem_out;
                    end
                end
            end
        end
    end

    // Memory port is driven only in ACC, so reset drops mem_we without waiting for a clock.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        if (state == ACC) begin
            if (owner) begin
                mem_we   = we1;
                mem_addr = addr1;
                mem_data = wdata1;
            end else begin
                mem_we   = we0;
                mem_addr = addr0;
                mem_data = wdata0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences and
// randomized two-master traffic checked against a shadow memory and arbitration rules.
module tb_mem_arbiter;
    localparam int AW = 6;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, mem_we, busy;
    logic [DW-1:0] rdata0, rdata1, mem_data, mem_out;
    logic [AW-1:0] mem_addr;

    int n_checks = 0;
    int n_fail = 0;

    // Clock and attached memory (synchronous write, combinational read)
    always #5 clk = ~clk;

    logic [DW-1:0] mem [64] = '{default: '0};
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_data;
    assign mem_out = mem[mem_addr];

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_out(mem_out),
        .busy(busy)
    );

    // Reference model state
    logic [DW-1:0] ref_mem [64];
    bit            ref_valid [64];

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } op_t;
    op_t q0[$];
    op_t q1[$];
    logic [0:0] exp_q[$];

    bit rand_on = 1'b0;
    bit last_ack = 1'b1;
    bit h0_1 = 1'b0, h0_2 = 1'b0, h1_1 = 1'b0, h1_2 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit id, input bit r, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        if (id) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_busy", busy, 0);
        last_ack = 1'b1;
        rst_n = 1'b1;
    endtask

    // One access from one requester; ack must land on the third falling edge after req rises.
    task automatic single_access(input bit id, input bit we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [DW-1:0] exp_r0,
                                 input logic [DW-1:0] exp_r1);
        int ack_at = 0;
        int wp = 0;
        @(posedge clk); #1;
        drive(id, 1'b1, we, addr, wdata);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (mem_we) begin
                wp++;
                chk("wr_addr", mem_addr, addr);
                chk("wr_data", mem_data, wdata);
            end
            if (id ? ack1 : ack0) begin
                ack_at = n;
                break;
            end
        end
        chk("ack_latency", ack_at, 3);
        chk("write_pulses", wp, we);
        chk("rdata0", rdata0, exp_r0);
        chk("rdata1", rdata1, exp_r1);
        @(posedge clk); #1;
        drive(id, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("ack_clear", id ? ack1 : ack0, 0);
        if (we) begin
            ref_mem[addr]   = wdata;
            ref_valid[addr] = 1'b1;
        end
    endtask

    task automatic rand_driver(input bit id, input int n_ops);
        op_t op;
        bit  got;
        for (int k = 0; k < n_ops; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk); #1;
            op.we    = ($urandom_range(0, 2) == 0);
            op.addr  = ($urandom_range(0, 5) == 0) ? 6'h3F : 6'($urandom_range(0, 7));
            op.wdata = 16'($urandom);
            if (id) q1.push_back(op); else q0.push_back(op);
            drive(id, 1'b1, op.we, op.addr, op.wdata);
            got = 1'b0;
            for (int n = 0; n < 20 && !got; n++) begin
                @(negedge clk);
                got = id ? ack1 : ack0;
            end
            if (!got) chk("rand_ack_timeout", 0, 1);
            @(posedge clk); #1;
            drive(id, 1'b0, 1'b0, '0, '0);
        end
    endtask

    // Continuous monitor: ack exclusivity, quiet memory port outside an access,
    // and during random traffic: data and tie-break rules.
    always @(negedge clk) begin
        op_t op;
        bit  id;
        bit  exp_id;
        if (ack0 || ack1) chk("ack_overlap", ack0 & ack1, 0);
        if (!busy) begin
            chk("idle_mem_we", mem_we, 0);
            chk("idle_mem_addr", mem_addr, 0);
            chk("idle_mem_data", mem_data, 0);
        end
        if (rand_on && (ack0 || ack1)) begin
            id = ack1;
            if (h0_2 && h1_2) begin
`ifdef ARB_FIXED_PRIO_EN
                exp_id = 1'b0;
`else
                exp_id = ~last_ack;
`endif
                chk("tie_winner", id, exp_id);
            end
            last_ack = id;
            chk("spurious_ack", (id ? q1.size() : q0.size()) > 0, 1);
            if ((id ? q1.size() : q0.size()) > 0) begin
                op = id ? q1.pop_front() : q0.pop_front();
                if (op.we) begin
                    ref_mem[op.addr]   = op.wdata;
                    ref_valid[op.addr] = 1'b1;
                end else if (ref_valid[op.addr]) begin
                    chk("rand_rdata", id ? rdata1 : rdata0, ref_mem[op.addr]);
                end
            end
        end
        h0_2 = h0_1; h0_1 = req0;
        h1_2 = h1_1; h1_1 = req1;
    end

    typedef struct {
        bit            id;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] r0;
        logic [DW-1:0] r1;
    } vec_t;
    vec_t vecs[11];

    initial begin
        int a0_at, a1_at, got, last_t;
        bit id;

        for (int i = 0; i < 64; i++) begin
            ref_mem[i]   = '0;
            ref_valid[i] = 1'b1;
        end
        vecs[0]  = '{1'b0, 1'b1, 6'h05, 16'hBEEF, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 6'h05, 16'h0000, 16'hBEEF, 16'h0000};
        vecs[2]  = '{1'b1, 1'b1, 6'h3F, 16'h1234, 16'hBEEF, 16'h0000};
        vecs[3]  = '{1'b1, 1'b0, 6'h3F, 16'h0000, 16'hBEEF, 16'h1234};
        vecs[4]  = '{1'b0, 1'b1, 6'h01, 16'h0A0A, 16'hBEEF, 16'h1234};
        vecs[5]  = '{1'b1, 1'b1, 6'h02, 16'h0B0B, 16'hBEEF, 16'h1234};
        vecs[6]  = '{1'b0, 1'b0, 6'h01, 16'h0000, 16'h0A0A, 16'h1234};
        vecs[7]  = '{1'b1, 1'b0, 6'h02, 16'h0000, 16'h0A0A, 16'h0B0B};
        vecs[8]  = '{1'b1, 1'b0, 6'h05, 16'h0000, 16'h0A0A, 16'hBEEF};
        vecs[9]  = '{1'b0, 1'b1, 6'h00, 16'hFFFF, 16'h0A0A, 16'hBEEF};
        vecs[10] = '{1'b0, 1'b0, 6'h00, 16'h0000, 16'hFFFF, 16'hBEEF};

        do_reset();
        for (int i = 0; i < 11; i++)
            single_access(vecs[i].id, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].r0, vecs[i].r1);

        // Simultaneous requests straight out of reset: requester 0 first, 1 three cycles later
        do_reset();
        a0_at = 0; a1_at = 0;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 6'h01, '0);
        drive(1'b1, 1'b1, 1'b0, 6'h02, '0);
        for (int n = 1; n <= 15 && a1_at == 0; n++) begin
            @(negedge clk);
            if (ack0) begin a0_at = n; #1 drive(1'b0, 1'b0, 1'b0, '0, '0); end
            if (ack1) begin a1_at = n; #1 drive(1'b1, 1'b0, 1'b0, '0, '0); end
        end
        chk("simul_ack0_at", a0_at, 3);
        chk("simul_ack1_at", a1_at, 6);
        chk("simul_rdata0", rdata0, ref_mem[1]);
        chk("simul_rdata1", rdata1, ref_mem[2]);
        repeat (2) @(negedge clk);

        // Continuous contention: both requests held for six accesses
        do_reset();
        for (int k = 0; k < 6; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            exp_q.push_back(1'b0);
`else
            exp_q.push_back(1'(k % 2));
`endif
        end
        got = 0; last_t = 0;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 6'h01, '0);
        drive(1'b1, 1'b1, 1'b0, 6'h02, '0);
        for (int n = 1; n <= 40 && got < 6; n++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                id = ack1;
                chk("grant_order", id, exp_q.pop_front());
                if (got > 0) chk("ack_spacing", n - last_t, 3);
                last_t = n;
                got++;
            end
        end
        chk("contention_count", got, 6);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        chk("contention_rdata0", rdata0, ref_mem[1]);
        repeat (3) @(negedge clk);

        // Reset during the ACC cycle of a requester-1 write
        do_reset();
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 6'h10, 16'h5555);
        @(negedge clk);
        @(negedge clk);
        chk("midacc_we_before", mem_we, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midacc_we_after", mem_we, 0);
        chk("midacc_busy", busy, 0);
        chk("midacc_ack1", ack1, 0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        ref_valid[6'h10] = 1'b0;
        last_ack = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midacc_no_ack1", ack1, 0);
            chk("midacc_rdata1", rdata1, 0);
        end
        single_access(1'b0, 1'b0, 6'h05, '0, ref_mem[5], 16'h0000);

        // Idle: no requests for 20 cycles
        repeat (20) begin
            @(negedge clk);
            chk("idle_we", mem_we, 0);
            chk("idle_addr", mem_addr, 0);
            chk("idle_busy", busy, 0);
        end

        // Randomized two-master traffic
        do_reset();
        rand_on = 1'b1;
        fork
            rand_driver(1'b0, 25);
            rand_driver(1'b1, 25);
        join
        repeat (4) @(negedge clk);
        rand_on = 1'b0;
        chk("rand_q0_drained", q0.size(), 0);
        chk("rand_q1_drained", q1.size(), 0);
        for (int i = 0; i < 64; i++)
            if (ref_valid[i]) chk("final_mem", mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port PicoComputer memory (synchronous write, combinational read).
- Requester 0 is the CPU fetch/execute path; requester 1 is the I/O or program-loader path.
- Grants one requester at a time, drives the memory's addr/we/data inputs, registers read data, and returns a one-cycle ack per completed access.

Parameters:
- ADDR_WIDTH, 6, memory address width; must match the attached memory.
- DATA_WIDTH, 16, memory word width.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req0  input  1  requester 0 access request, held high until ack0
- we0  input  1  requester 0 write enable (1 = write, 0 = read), stable while req0 high
- addr0  input  ADDR_WIDTH  requester 0 address, stable while req0 high
- wdata0  input  DATA_WIDTH  requester 0 write data, stable while req0 high
- ack0  output  1  one-cycle pulse: requester 0 access complete
- rdata0  output  DATA_WIDTH  requester 0 read data, valid with ack0, held until its next read
- req1, we1, addr1, wdata1, ack1, rdata1  same as above for requester 1
- mem_we  output  1  to memory we
- mem_addr  output  ADDR_WIDTH  to memory addr
- mem_data  output  DATA_WIDTH  to memory data
- mem_out  input  DATA_WIDTH  from memory out (combinational read)
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset (asynchronous, active-low) sets all of the following:
  - state = IDLE, owner = 0, last_owner = 1 (so requester 0 wins the first tie);
  - ack0, ack1 = 0; rdata0, rdata1 = 0;
  - mem_we = 0, mem_addr = 0, mem_data = 0; busy = 0.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - no req: stay.
  - one req: latch owner = that index, go to ACC.
  - both req: round-robin; owner = the index not equal to last_owner, go to ACC.
- ACC (exactly one cycle):
  - mem_addr and mem_data mux from the owner's inputs; mem_we = owner's we.
  - All mux outputs are combinational from the owner/state registers.
  - On the clock edge ending ACC:
    - read: rdata[owner] <= mem_out; write: the memory performs its write and rdata[owner] is unchanged.
    - ack[owner] <= 1, last_owner <= owner, go to DONE.
- DONE (one cycle):
  - ack[owner] is high; mem_we = 0.
  - The requester deasserts req on the following cycle.
  - Go to IDLE; ack clears on the exit edge.
- Outside ACC: mem_we = 0, mem_addr = 0, mem_data = 0. No spurious writes are permitted.
- Latency: req sampled high in IDLE at edge N → ACC in cycle N+1 → ack in cycle N+2. The next grant is no earlier than cycle N+3.
  - Back-to-back throughput is one access per 3 cycles.
  - Two continuously requesting masters alternate strictly.
- A req that drops before ack (protocol violation) does not abort an access already in ACC; the ack is still issued.
- A req held high during DONE is not re-granted until IDLE. The requester must drop req after ack or it issues a new access.
- Reset mid-ACC: mem_we falls immediately (asynchronous). The access is discarded with no ack and no rdata update. The memory content at that address is not guaranteed.
- ack0 and ack1 are never high in the same cycle.

Optional Feature:
- ARB_FIXED_PRIO_EN
  - Defined: requester 0 always wins simultaneous requests; last_owner is ignored. Requester 1 is served only in cycles where req0 is low in IDLE.
  - Undefined: round-robin as specified above.

Test Plan:
- Reset then write: req0=1, we0=1, addr0=0x05, wdata0=0xBEEF → mem_we=1 and mem_addr=0x05 for exactly one cycle, ack0 two cycles after grant. Then req0 read of 0x05 → rdata0=0xBEEF with ack0.
- Simultaneous requests from reset: req0 and req1 both rise (req0 read 0x01, req1 read 0x02) → requester 0 served first (ack0), then requester 1 (ack1, three cycles later). ack0 and ack1 never overlap.
- Continuous contention: both reqs held and re-raised for 6 accesses → grant order 0,1,0,1,0,1 (with ARB_FIXED_PRIO_EN: all six go to requester 0 while req0 stays high).
- Isolation: requester 1 writes 0x1234 to 0x3F while rdata0 holds 0xBEEF → rdata0 unchanged; a later req1 read of 0x3F returns 0x1234 on rdata1.
- Reset mid-ACC: assert rst_n=0 during a req1 write's ACC cycle → mem_we drops the same cycle, no ack1, busy=0. After release, a req0 read completes normally in 3 cycles.
- Idle check: no requests for 20 cycles → mem_we=0, mem_addr=0, busy=0 throughout.
